// File: rtl/register_scoreboard.sv
// Per-register pending-write scoreboard for GPR, FPR and EFLAGS with RAW/saturation stall.
// Optional stall counter output enabled by defining SCOREBOARD_STATS_EN.
module register_scoreboard #(
  parameter  int NREG  = 16,
  parameter  int CNT_W = 2,
  localparam int IW    = $clog2(NREG),
  localparam int RUT_W = 3 * IW + 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  // rut layout, MSB first: d, s, t, from_gd, from_fd, to_gd, to_fd,
  // from_gs, from_fs, from_gt, from_ft, from_ef, to_ef
  input  logic [RUT_W-1:0] rut,
  output logic             issue_ready,
  input  logic             wb_gd_valid,
  input  logic [IW-1:0]    wb_gd,
  input  logic             wb_fd_valid,
  input  logic [IW-1:0]    wb_fd,
  input  logic             wb_ef_valid,
  input  logic             flush,
  output logic [NREG-1:0]  gpr_pending,
  output logic [NREG-1:0]  fpr_pending,
  output logic             ef_pending,
  output logic             busy
`ifdef SCOREBOARD_STATS_EN
  , output logic [31:0]    stall_cnt
`endif
);

  typedef struct packed {
    logic [IW-1:0] d;
    logic [IW-1:0] s;
    logic [IW-1:0] t;
    logic from_gd;
    logic from_fd;
    logic to_gd;
    logic to_fd;
    logic from_gs;
    logic from_fs;
    logic from_gt;
    logic from_ft;
    logic from_ef;
    logic to_ef;
  } rut_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rut_t             u;
  logic [CNT_W-1:0] gcnt [NREG];
  logic [CNT_W-1:0] fcnt [NREG];
  logic [CNT_W-1:0] ecnt;
  logic             raw_hazard;
  logic             sat_hazard;
  logic             accept;

  assign u = rut;

  // Hazards look only at current counters; a same-cycle writeback does not clear them.
  assign raw_hazard = (u.from_gs && gcnt[u.s] != '0) ||
                      (u.from_gt && gcnt[u.t] != '0) ||
                      (u.from_gd && gcnt[u.d] != '0) ||
                      (u.from_fs && fcnt[u.s] != '0) ||
                      (u.from_ft && fcnt[u.t] != '0) ||
                      (u.from_fd && fcnt[u.d] != '0) ||
                      (u.from_ef && ecnt != '0);

  assign sat_hazard = (u.to_gd && gcnt[u.d] == CNT_MAX) ||
                      (u.to_fd && fcnt[u.d] == CNT_MAX) ||
                      (u.to_ef && ecnt == CNT_MAX);

  assign issue_ready = !flush && !raw_hazard && !sat_hazard;
  assign accept      = issue_valid && issue_ready;

  // Writeback to an idle counter is dropped; increment cannot overflow because
  // a saturated target blocks issue.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic dec_eff;
    dec_eff = dec && (c != '0);
    if (inc && !dec_eff)      return c + CNT_W'(1);
    else if (dec_eff && !inc) return c - CNT_W'(1);
    else                      return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        gcnt[i] <= '0;
        fcnt[i] <= '0;
      end
      ecnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) begin
        gcnt[i] <= '0;
        fcnt[i] <= '0;
      end
      ecnt <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        gcnt[i] <= next_cnt(gcnt[i], accept && u.to_gd && (u.d == IW'(i)),
                            wb_gd_valid && (wb_gd == IW'(i)));
        fcnt[i] <= next_cnt(fcnt[i], accept && u.to_fd && (u.d == IW'(i)),
                            wb_fd_valid && (wb_fd == IW'(i)));
      end
      ecnt <= next_cnt(ecnt, accept && u.to_ef, wb_ef_valid);
    end
  end

  always_comb begin
    gpr_pending = '0;
    fpr_pending = '0;
    for (int i = 0; i < NREG; i++) begin
      gpr_pending[i] = (gcnt[i] != '0);
      fpr_pending[i] = (fcnt[i] != '0);
    end
  end

  assign ef_pending = (ecnt != '0);
  assign busy       = (|gpr_pending) || (|fpr_pending) || ef_pending;

`ifdef SCOREBOARD_STATS_EN
  // Counts stalled issue attempts; only rst clears it, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed self-checking bench for register_scoreboard (NREG=16, CNT_W=2).
// Stats checks compile in when SCOREBOARD_STATS_EN is defined.
module tb_register_scoreboard;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] s;
    logic [3:0] t;
    logic from_gd;
    logic from_fd;
    logic to_gd;
    logic to_fd;
    logic from_gs;
    logic from_fs;
    logic from_gt;
    logic from_ft;
    logic from_ef;
    logic to_ef;
  } tb_rut_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  tb_rut_t     r = '0;
  logic [21:0] rut;
  logic        issue_ready;
  logic        wb_gd_valid = 1'b0;
  logic [3:0]  wb_gd = '0;
  logic        wb_fd_valid = 1'b0;
  logic [3:0]  wb_fd = '0;
  logic        wb_ef_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] gpr_pending;
  logic [15:0] fpr_pending;
  logic        ef_pending;
  logic        busy;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  assign rut = r;

  register_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .rut(rut),
    .issue_ready(issue_ready),
    .wb_gd_valid(wb_gd_valid), .wb_gd(wb_gd),
    .wb_fd_valid(wb_fd_valid), .wb_fd(wb_fd),
    .wb_ef_valid(wb_ef_valid), .flush(flush),
    .gpr_pending(gpr_pending), .fpr_pending(fpr_pending),
    .ef_pending(ef_pending), .busy(busy)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    r = '0;
    wb_gd_valid = 1'b0;
    wb_fd_valid = 1'b0;
    wb_ef_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #12;
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL reset_gpr got %h exp 0000", gpr_pending); end
    checks++; if (fpr_pending !== 16'h0) begin errors++; $display("FAIL reset_fpr got %h exp 0000", fpr_pending); end
    checks++; if (ef_pending !== 1'b0) begin errors++; $display("FAIL reset_ef got %b exp 0", ef_pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
    // An edge while rst is held must not record the accept
    r.to_gd = 1'b1; r.d = 4'd0; issue_valid = 1'b1;
    step();
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL reset_hold got %h exp 0000", gpr_pending); end
    idle();
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    r = '0; r.d = 4'd3; r.s = 4'd1; r.from_gs = 1'b1; r.to_gd = 1'b1; r.to_ef = 1'b1;
    issue_valid = 1'b1;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL addi_ready got %b exp 1", issue_ready); end
    step(); idle();
    checks++; if (gpr_pending !== 16'h0008) begin errors++; $display("FAIL addi_gpr got %h exp 0008", gpr_pending); end
    checks++; if (ef_pending !== 1'b1) begin errors++; $display("FAIL addi_ef got %b exp 1", ef_pending); end
    checks++; if (fpr_pending !== 16'h0) begin errors++; $display("FAIL addi_fpr got %h exp 0000", fpr_pending); end
  endtask

  task automatic test_raw();
    r = '0; r.d = 4'd6; r.s = 4'd3; r.t = 4'd4; r.from_gs = 1'b1; r.from_gt = 1'b1; r.to_gd = 1'b1;
    issue_valid = 1'b1;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", issue_ready); end
    step();
    checks++; if (gpr_pending !== 16'h0008) begin errors++; $display("FAIL raw_not_recorded got %h exp 0008", gpr_pending); end
    wb_gd_valid = 1'b1; wb_gd = 4'd3;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_same_cycle got %b exp 0", issue_ready); end
    step(); wb_gd_valid = 1'b0;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", issue_ready); end
    step(); idle();
    checks++; if (gpr_pending !== 16'h0040) begin errors++; $display("FAIL raw_issued got %h exp 0040", gpr_pending); end
    checks++; if (ef_pending !== 1'b1) begin errors++; $display("FAIL raw_ef_kept got %b exp 1", ef_pending); end
    wb_gd_valid = 1'b1; wb_gd = 4'd6; wb_ef_valid = 1'b1;
    step(); idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL raw_drain got %b exp 0", busy); end
  endtask

  task automatic test_bank_independence();
    r = '0; r.d = 4'd3; r.to_fd = 1'b1; issue_valid = 1'b1;
    step(); idle();
    checks++; if (fpr_pending !== 16'h0008) begin errors++; $display("FAIL bank_fpr got %h exp 0008", fpr_pending); end
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL bank_gpr got %h exp 0000", gpr_pending); end
    r = '0; r.s = 4'd3; r.d = 4'd3; r.from_gs = 1'b1; r.from_gd = 1'b1; issue_valid = 1'b1;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bank_gpr_src got %b exp 1", issue_ready); end
    r = '0; r.s = 4'd3; r.from_fs = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bank_fpr_src got %b exp 0", issue_ready); end
    step(); idle();
    wb_gd_valid = 1'b1; wb_gd = 4'd3;
    step(); idle();
    checks++; if (fpr_pending !== 16'h0008 || gpr_pending !== 16'h0) begin errors++; $display("FAIL bank_wb_cross got f=%h g=%h exp f=0008 g=0000", fpr_pending, gpr_pending); end
    wb_fd_valid = 1'b1; wb_fd = 4'd3;
    step(); idle();
    checks++; if (fpr_pending !== 16'h0) begin errors++; $display("FAIL bank_fpr_drain got %h exp 0000", fpr_pending); end
  endtask

  task automatic test_saturation();
    r = '0; r.d = 4'd5; r.to_gd = 1'b1; issue_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL movi_%0d got %b exp 1", k, issue_ready); end
      step();
    end
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL movi_sat got %b exp 0", issue_ready); end
    step();
    wb_gd_valid = 1'b1; wb_gd = 4'd5;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_wb_same got %b exp 0", issue_ready); end
    step(); wb_gd_valid = 1'b0;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sat_count2 got %b exp 1", issue_ready); end
    step();
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sat_again got %b exp 0", issue_ready); end
    idle();
    wb_gd_valid = 1'b1; wb_gd = 4'd5;
    step(); step();
    checks++; if (gpr_pending !== 16'h0020) begin errors++; $display("FAIL sat_drain2 got %h exp 0020", gpr_pending); end
    step();
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL sat_drain3 got %h exp 0000", gpr_pending); end
    step(); idle();
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL wb_at_zero got %h exp 0000", gpr_pending); end
    r.d = 4'd5; r.to_gd = 1'b1; issue_valid = 1'b1;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL no_underflow got %b exp 1", issue_ready); end
    step(); idle();
    checks++; if (gpr_pending !== 16'h0020) begin errors++; $display("FAIL reissue got %h exp 0020", gpr_pending); end
    wb_gd_valid = 1'b1; wb_gd = 4'd5;
    step(); idle();
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL reissue_drain got %h exp 0000", gpr_pending); end
  endtask

  task automatic test_same_cycle();
    r = '0; r.d = 4'd2; r.to_gd = 1'b1; issue_valid = 1'b1;
    step();
    wb_gd_valid = 1'b1; wb_gd = 4'd2;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b exp 1", issue_ready); end
    step(); idle();
    checks++; if (gpr_pending !== 16'h0004) begin errors++; $display("FAIL same_pending got %h exp 0004", gpr_pending); end
    wb_gd_valid = 1'b1; wb_gd = 4'd2;
    step(); idle();
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL same_count1 got %h exp 0000", gpr_pending); end
  endtask

  task automatic test_flush();
    r = '0; r.d = 4'd1; r.to_gd = 1'b1; r.to_ef = 1'b1; issue_valid = 1'b1;
    step();
    r = '0; r.d = 4'd7; r.to_fd = 1'b1;
    step(); idle();
    checks++; if (gpr_pending !== 16'h0002 || fpr_pending !== 16'h0080 || ef_pending !== 1'b1) begin
      errors++; $display("FAIL flush_load got g=%h f=%h e=%b exp g=0002 f=0080 e=1", gpr_pending, fpr_pending, ef_pending);
    end
    flush = 1'b1; issue_valid = 1'b1; r.d = 4'd9; r.to_gd = 1'b1;
    wb_gd_valid = 1'b1; wb_gd = 4'd1;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", issue_ready); end
    step(); idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    checks++; if (gpr_pending !== 16'h0) begin errors++; $display("FAIL flush_not_recorded got %h exp 0000", gpr_pending); end
  endtask

  task automatic test_nop_and_async_reset();
    r = '0; r.d = 4'd4; r.to_gd = 1'b1; r.to_ef = 1'b1; issue_valid = 1'b1;
    step();
    r = '0;
    @(negedge clk);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL nop_ready got %b exp 1", issue_ready); end
    step(); idle();
    checks++; if (gpr_pending !== 16'h0010 || ef_pending !== 1'b1) begin errors++; $display("FAIL nop_no_change got g=%h e=%b exp g=0010 e=1", gpr_pending, ef_pending); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || gpr_pending !== 16'h0) begin errors++; $display("FAIL async_reset got busy=%b g=%h exp busy=0 g=0000", busy, gpr_pending); end
    #1 rst = 1'b0;
    step();
    r.d = 4'd4; r.to_gd = 1'b1; issue_valid = 1'b1;
    step(); idle();
    checks++; if (gpr_pending !== 16'h0010) begin errors++; $display("FAIL post_reset_issue got %h exp 0010", gpr_pending); end
    wb_gd_valid = 1'b1; wb_gd = 4'd4;
    step(); idle();
  endtask

`ifdef SCOREBOARD_STATS_EN
  task automatic test_stats();
    rst = 1'b1; #2 rst = 1'b0;
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_reset got %0d exp 0", stall_cnt); end
    step();
    r = '0; r.d = 4'd3; r.to_gd = 1'b1; issue_valid = 1'b1;
    step();
    r = '0; r.s = 4'd3; r.from_gs = 1'b1; issue_valid = 1'b1;
    repeat (5) step();
    idle();
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stats_5 got %0d exp 5", stall_cnt); end
    flush = 1'b1;
    step(); idle();
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stats_flush got %0d exp 5", stall_cnt); end
    rst = 1'b1; #1;
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_rst got %0d exp 0", stall_cnt); end
    rst = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_raw();
    test_bank_independence();
    test_saturation();
    test_same_cycle();
    test_flush();
    test_nop_and_async_reset();
`ifdef SCOREBOARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
